// File: rtl/serial_deser_if.sv
// serial_deser_if: serial-side and word-side handshake bundle for serial_deser.
//   Serial side : s_in, s_valid, s_ready, dir_sel, frame_start
//   Word side   : p_out[W-1:0], p_valid, p_ready, p_err
//   Modports    : slave  = the receiver (serial_deser)
//                 master = the environment driving bits and consuming words
interface serial_deser_if #(
    parameter int unsigned W = 8
);
    logic         s_in;
    logic         s_valid;
    logic         s_ready;
    logic         dir_sel;
    logic         frame_start;
    logic [W-1:0] p_out;
    logic         p_valid;
    logic         p_ready;
    logic         p_err;

    modport slave (
        input  s_in, s_valid, dir_sel, frame_start, p_ready,
        output s_ready, p_out, p_valid, p_err
    );

    modport master (
        output s_in, s_valid, dir_sel, frame_start, p_ready,
        input  s_ready, p_out, p_valid, p_err
    );
endinterface

// File: rtl/serial_deser.sv
// serial_deser: serial-to-parallel receiver with a one-entry output holding register.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : serial_deser_if.slave
//           s_in/s_valid/s_ready  one bit per accepted cycle
//           dir_sel               bit order latched on bit 0 (0 = MSB-first, 1 = LSB-first)
//           frame_start           clears bit count and shift register
//           p_out/p_valid/p_ready assembled word handshake
//           p_err                 even-parity error for p_out
// Optional feature macro: DESER_PARITY_EN (one even-parity bit follows each word).
module serial_deser #(
    parameter int unsigned W = 8
) (
    input  logic          clk,
    input  logic          reset,
    serial_deser_if.slave bus
);
`ifdef DESER_PARITY_EN
    localparam int unsigned L  = W;
`else
    localparam int unsigned L  = W - 1;
`endif
    localparam int unsigned CW = $clog2(W + 1);

    logic [W-1:0]  sr_q, sr_d, sr_eff, sr_shift;
    logic [W-1:0]  p_out_q, p_out_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_eff;
    logic          ord_q, ord_d, ord_eff;
    logic          p_valid_q, p_valid_d;
    logic          s_ready_c, accept, complete;
`ifdef DESER_PARITY_EN
    logic          p_err_q, p_err_d;
`endif

    // Handshake and effective (frame_start-adjusted) word state.
    always_comb begin
        s_ready_c = (cnt_q != CW'(L)) || !p_valid_q || bus.p_ready;
        accept    = bus.s_valid && s_ready_c;
        cnt_eff   = bus.frame_start ? '0 : cnt_q;
        sr_eff    = bus.frame_start ? '0 : sr_q;
        // Order is taken from dir_sel only on bit 0; later changes are ignored.
        ord_eff   = (cnt_eff == '0) ? bus.dir_sel : ord_q;
        sr_shift  = ord_eff ? {bus.s_in, sr_eff[W-1:1]} : {sr_eff[W-2:0], bus.s_in};
        complete  = accept && (cnt_eff == CW'(L));
    end

    // Next-state for shift register, counter and holding register.
    always_comb begin
        sr_d      = sr_eff;
        cnt_d     = cnt_eff;
        ord_d     = ord_q;
        p_out_d   = p_out_q;
        p_valid_d = p_valid_q;
`ifdef DESER_PARITY_EN
        p_err_d   = p_err_q;
`endif
        if (p_valid_q && bus.p_ready) begin
            p_valid_d = 1'b0;
        end
        if (accept) begin
            ord_d = ord_eff;
            if (complete) begin
                cnt_d     = '0;
                sr_d      = '0;
                p_valid_d = 1'b1;
`ifdef DESER_PARITY_EN
                // Last accepted bit is the parity bit; it never enters sr.
                p_out_d   = sr_eff;
                p_err_d   = (^sr_eff) ^ bus.s_in;
`else
                p_out_d   = sr_shift;
`endif
            end else begin
                // Every non-final bit is a data bit in both configurations.
                cnt_d = cnt_eff + CW'(1);
                sr_d  = sr_shift;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_q      <= '0;
            cnt_q     <= '0;
            ord_q     <= 1'b0;
            p_out_q   <= '0;
            p_valid_q <= 1'b0;
        end else begin
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
            ord_q     <= ord_d;
            p_out_q   <= p_out_d;
            p_valid_q <= p_valid_d;
        end
    end

`ifdef DESER_PARITY_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p_err_q <= 1'b0;
        end else begin
            p_err_q <= p_err_d;
        end
    end
    assign bus.p_err = p_err_q;
`else
    assign bus.p_err = 1'b0;
`endif

    assign bus.s_ready = s_ready_c;
    assign bus.p_out   = p_out_q;
    assign bus.p_valid = p_valid_q;
endmodule

// File: tb/tb_serial_deser.sv
// tb_serial_deser: directed self-checking bench for serial_deser (W = 8).
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
module tb_serial_deser;
    localparam int unsigned W = 8;
`ifdef DESER_PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif

    logic clk;
    logic reset;
    int   tests;
    int   failed;

    serial_deser_if #(.W(W)) bus ();

    serial_deser #(.W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Stream bits MSB-of-vector first; dir_sel is toggled after bit 0 to prove it is ignored.
    // In the parity build a parity bit (even, optionally flipped) follows the data.
    task automatic send_word(input logic [7:0] bits, input logic dir, input logic flip);
        logic [8:0] st;
        st = {bits, (^bits) ^ flip};
        for (int i = 0; i < NB; i++) begin
            bus.s_in    = st[8-i];
            bus.dir_sel = (i == 0) ? dir : ~dir;
            bus.s_valid = 1'b1;
            @(posedge clk); #1;
        end
        bus.s_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
    endtask

    initial begin
        logic [8:0] st;
        tests = 0;
        failed = 0;
        bus.s_in = 1'b0;
        bus.s_valid = 1'b0;
        bus.dir_sel = 1'b0;
        bus.frame_start = 1'b0;
        bus.p_ready = 1'b1;
        reset = 1'b0;
        #12;
        check("rst_p_valid", 32'(bus.p_valid), 32'd0);
        check("rst_p_out",   32'(bus.p_out),   32'h00);
        check("rst_p_err",   32'(bus.p_err),   32'd0);
        check("rst_s_ready", 32'(bus.s_ready), 32'd1);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;

        // MSB-first decode
        send_word(8'hCA, 1'b0, 1'b0);
        check("msb_p_valid", 32'(bus.p_valid), 32'd1);
        check("msb_p_out",   32'(bus.p_out),   32'hCA);
        check("msb_p_err",   32'(bus.p_err),   32'd0);
        idle_cycle();
        check("msb_one_cycle", 32'(bus.p_valid), 32'd0);
        check("msb_hold_out",  32'(bus.p_out),   32'hCA);

        // LSB-first decode, dir_sel toggled mid-word
        send_word(8'hCA, 1'b1, 1'b0);
        check("lsb_p_valid", 32'(bus.p_valid), 32'd1);
        check("lsb_p_out",   32'(bus.p_out),   32'h53);
        idle_cycle();
        check("lsb_one_cycle", 32'(bus.p_valid), 32'd0);

        // Back-to-back words with no idle cycle
        send_word(8'h35, 1'b0, 1'b0);
        check("b2b_first", 32'(bus.p_out), 32'h35);
        send_word(8'hCA, 1'b0, 1'b0);
        check("b2b_second", 32'(bus.p_out), 32'hCA);
        check("b2b_valid",  32'(bus.p_valid), 32'd1);
        idle_cycle();

        // Backpressure: hold 0xCA, stream 0x35, stall on the last bit
        bus.p_ready = 1'b0;
        send_word(8'hCA, 1'b0, 1'b0);
        check("bp_first_valid", 32'(bus.p_valid), 32'd1);
        st = {8'h35, ^8'h35};
        for (int i = 0; i < NB - 1; i++) begin
            bus.s_in = st[8-i];
            bus.dir_sel = 1'b0;
            bus.s_valid = 1'b1;
            @(posedge clk); #1;
        end
        bus.s_in = st[8-(NB-1)];
        #1;
        check("bp_stall_ready", 32'(bus.s_ready), 32'd0);
        @(posedge clk); #1;
        check("bp_hold_out",    32'(bus.p_out),   32'hCA);
        check("bp_hold_valid",  32'(bus.p_valid), 32'd1);
        check("bp_still_stall", 32'(bus.s_ready), 32'd0);
        bus.p_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(bus.s_ready), 32'd1);
        @(posedge clk); #1;
        bus.s_valid = 1'b0;
        check("bp_new_out",   32'(bus.p_out),   32'h35);
        check("bp_new_valid", 32'(bus.p_valid), 32'd1);
        idle_cycle();
        check("bp_drained", 32'(bus.p_valid), 32'd0);

        // Alignment: 3 stray bits, frame_start idle cycle, then a full word
        for (int i = 0; i < 3; i++) begin
            bus.s_in = 1'(i & 1);
            bus.s_valid = 1'b1;
            @(posedge clk); #1;
        end
        bus.s_valid = 1'b0;
        bus.frame_start = 1'b1;
        idle_cycle();
        bus.frame_start = 1'b0;
        check("fs_no_valid", 32'(bus.p_valid), 32'd0);
        send_word(8'hCA, 1'b0, 1'b0);
        check("fs_p_out", 32'(bus.p_out), 32'hCA);
        idle_cycle();

        // frame_start coincident with a bit: that bit is bit 0 (LSB-first word)
        for (int i = 0; i < 2; i++) begin
            bus.s_in = 1'b1;
            bus.dir_sel = 1'b0;
            bus.s_valid = 1'b1;
            @(posedge clk); #1;
        end
        bus.frame_start = 1'b1;
        bus.s_in = 1'b1;
        bus.dir_sel = 1'b1;
        @(posedge clk); #1;
        bus.frame_start = 1'b0;
        st = {8'hCA, ^8'hCA};
        for (int i = 1; i < NB; i++) begin
            bus.s_in = st[8-i];
            bus.dir_sel = 1'b0;
            @(posedge clk); #1;
        end
        bus.s_valid = 1'b0;
        check("fs_coinc_out", 32'(bus.p_out), 32'h53);
        idle_cycle();

        // Reset mid-word with a held word
        bus.p_ready = 1'b0;
        send_word(8'h35, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            bus.s_in = 1'b1;
            bus.s_valid = 1'b1;
            @(posedge clk); #1;
        end
        bus.s_valid = 1'b0;
        reset = 1'b0;
        #1;
        check("mrst_p_valid", 32'(bus.p_valid), 32'd0);
        check("mrst_p_out",   32'(bus.p_out),   32'h00);
        check("mrst_p_err",   32'(bus.p_err),   32'd0);
        check("mrst_s_ready", 32'(bus.s_ready), 32'd1);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        bus.p_ready = 1'b1;
        send_word(8'hCA, 1'b0, 1'b0);
        check("mrst_after_out",   32'(bus.p_out),   32'hCA);
        check("mrst_after_valid", 32'(bus.p_valid), 32'd1);
        idle_cycle();

`ifdef DESER_PARITY_EN
        send_word(8'hCA, 1'b0, 1'b0);
        check("par_ok_out", 32'(bus.p_out), 32'hCA);
        check("par_ok_err", 32'(bus.p_err), 32'd0);
        send_word(8'hCA, 1'b0, 1'b1);
        check("par_bad_out", 32'(bus.p_out), 32'hCA);
        check("par_bad_err", 32'(bus.p_err), 32'd1);
        idle_cycle();
`else
        send_word(8'hFF, 1'b0, 1'b0);
        check("nopar_out", 32'(bus.p_out), 32'hFF);
        check("nopar_err", 32'(bus.p_err), 32'd0);
        idle_cycle();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/serial_deser.md
# serial_deser

Serial-to-parallel receiver: the receiving end of the shift-register serial link. Accepts one bit per cycle under a valid/ready handshake, assembles W-bit words MSB-first or LSB-first, and presents each completed word in a one-entry output holding register with its own valid/ready handshake. It sits between a serial link and word-oriented logic such as register files or FIFOs.

## Interface
- W, 8, data word width in bits (W >= 2)
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- frame_start  input  1  synchronous word-alignment pulse: clears bit count and shift register
- dir_sel  input  1  bit order, sampled on the first bit of each word: 0 = MSB-first, 1 = LSB-first
- s_in  input  1  serial data bit
- s_valid  input  1  s_in is valid this cycle
- s_ready  output  1  block accepts s_in this cycle
- p_out  output  W  assembled word, held stable while p_valid is high
- p_valid  output  1  p_out holds an unconsumed word
- p_ready  input  1  consumer takes p_out this cycle
- p_err  output  1  parity error for the word in p_out; 0 without DESER_PARITY_EN

## Operation
- A bit is accepted when s_valid && s_ready at a clk edge.
- Internal state: shift register sr[W-1:0], bit counter cnt, latched order bit ord, holding register p_out/p_valid/p_err.
- Last-bit index L = W-1, or W with DESER_PARITY_EN.
- Accept with cnt==0: ord <= dir_sel. Later bits use ord; dir_sel changes mid-word are ignored.
- Data bit accept, cnt < W:
  - ord=0: sr <= {sr[W-2:0], s_in}, so the first bit lands in the MSB.
  - ord=1: sr <= {s_in, sr[W-1:1]}, so the first bit lands in the LSB.
- Accept with cnt < L: cnt <= cnt+1.
- Accept with cnt == L: word completes.
  - p_out <= final word, which includes the bit just accepted when no parity bit is configured.
  - p_valid <= 1; cnt <= 0; sr <= 0.
- s_ready = (cnt != L) || !p_valid || p_ready (combinational).
  - Stall occurs only on the last bit while the holding register is full and not draining.
- Consumer handshake: p_valid && p_ready clears p_valid, unless a word completes in the same cycle. In that case the new word is loaded and p_valid stays 1.
- frame_start: cnt <= 0 and sr <= 0; p_out, p_valid and p_err are unaffected.
  - If frame_start coincides with a bit accept, the bit is taken as bit 0 of the new word, with ord <= dir_sel.
- Reset: p_out=0, p_valid=0, p_err=0, cnt=0, sr=0, ord=0. s_ready is 1 after reset.
  - Reset during a word discards the partial word and any held word.

## Timing
- Latency: p_valid rises on the clk edge that accepts bit L, so it is visible the cycle after that bit is presented.
- Throughput: one bit per cycle; back-to-back words have no idle cycles when p_ready is held high.
- p_out and p_err are registered and change only on a word completion or reset.
- s_ready depends combinationally on p_ready; there is no combinational path from s_valid to s_ready.

## Configuration
- DESER_PARITY_EN defined:
  - The stream carries W data bits followed by one even-parity bit, so L = W.
  - The parity bit does not enter sr.
  - At completion, p_err <= (^sr) ^ parity_bit, so a mismatch gives 1.
- DESER_PARITY_EN undefined:
  - L = W-1, and the word completes on the W-th data bit.
  - p_err is tied to 0.

## Test plan
- MSB-first decode, W=8, dir_sel=0, p_ready=1, bits 1,1,0,0,1,0,1,0 on consecutive cycles -> p_out=0xCA and p_valid=1 for exactly one cycle after the 8th bit.
- LSB-first decode, dir_sel=1 with the same bits -> p_out=0x53. Toggling dir_sel after bit 0 does not change the result.
- Backpressure: word 0xCA is held with p_ready=0 while the next 8 bits are streamed.
  - s_ready=0 while the 8th bit is presented; p_out stays 0xCA.
  - Raising p_ready accepts the 8th bit the same cycle; the next p_out is the new word and p_valid stays 1.
- Alignment and reset:
  - Send 3 bits, then frame_start, then 1,1,0,0,1,0,1,0 -> p_out=0xCA.
  - Assert reset after 5 bits -> all outputs 0; the next full 8 bits decode correctly.
- Parity, with DESER_PARITY_EN: data 0xCA (four ones) followed by parity 0 -> p_err=0; followed by parity 1 -> p_err=1.
- Without DESER_PARITY_EN: p_err stays 0 throughout.
